fpu_sub_seq: RTL and testbench
==============================

FPU_SUB_SEQ -- requirements
Module: fpu_sub_seq

Interface
REQ-001 clk  input  1  single clock; every register updates on the rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 ip1  input  32  IEEE-754 single-precision minuend: sign [31], exponent [30:23], fraction [22:0].
REQ-004 ip2  input  32  IEEE-754 single-precision subtrahend, same layout as ip1.
REQ-005 in_valid  input  1  ip1/ip2 are valid this cycle.
REQ-006 in_ready  output  1  block can accept operands (high only in IDLE).
REQ-007 result  output  32  ip1 - ip2, single precision.
REQ-008 out_valid  output  1  result is valid; held until accepted.
REQ-009 out_ready  input  1  consumer accepts result.

Function
REQ-010 SHALL compute ip1 - ip2 by inverting ip2[31] and performing signed-magnitude addition; hidden bit is 1 when exponent != 0.
REQ-011 SHALL use FSM states IDLE, ALIGN, ADD, NORM, DONE.
REQ-012 IDLE: in_ready=1; on in_valid&&in_ready SHALL capture operands, swap so operand A has the larger {exp,fraction} magnitude, and load diff = expA - expB (8-bit unsigned).
REQ-013 IDLE exit: SHALL go to ALIGN when diff!=0 and B mantissa!=0, otherwise to ADD.
REQ-014 ALIGN: SHALL shift B mantissa right 1 bit per cycle and decrement diff; discarded bits are truncated; SHALL go to ADD when diff reaches 0 or B mantissa becomes 0 (capping ALIGN at 24 cycles).
REQ-015 ADD, equal signs: SHALL form 25-bit sum = A + B; on carry (bit 24) SHALL shift right 1 and increment exponent; an exponent reaching 255 SHALL give result {signA, 8'hFF, 23'h0}.
REQ-016 ADD, opposite signs: SHALL form A - B (never negative after the swap); result sign = signA.
REQ-017 ADD exit: zero magnitude SHALL produce exactly +0 (32'h00000000) and go to DONE; bit 23 clear SHALL go to NORM; otherwise go to DONE.
REQ-018 NORM: SHALL shift the mantissa left 1 bit per cycle and decrement exponent until bit 23 is set; if the exponent would reach 0, SHALL flush result to signed zero {signA, 31'h0} and go to DONE.
REQ-019 Zero/denormal inputs (exp==0) SHALL be treated as zero; ip1 zero gives result = ip2 with sign inverted; ip2 zero gives result = ip1.
REQ-020 An input with exp==255 SHALL give result 32'h7FC00000 through IDLE -> DONE.
REQ-021 DONE: out_valid=1 and result stable; on out_ready SHALL return to IDLE with out_valid=0 on the next cycle.
REQ-022 No new operands SHALL be accepted before the current result is handed off; in_valid outside IDLE is ignored.
REQ-023 Latency, handshake cycle to first out_valid cycle: 2 + ALIGN cycles + NORM cycles.
REQ-024 Rounding: truncation only; no sticky, guard or round bits.

Reset
REQ-025 rst SHALL force IDLE, in_ready=1, out_valid=0, result=32'h0, and clear all datapath registers.
REQ-026 rst asserted in any state, including mid-ALIGN/NORM or DONE awaiting out_ready, SHALL abandon the operation with no out_valid pulse.

Structure
REQ-027 The state encoding and the constants QNAN=32'h7FC00000, EXP_MAX=8'hFF and MANT_W=24 SHALL be defined in shared package fpu_pkg.
REQ-028 The block SHALL contain one sub-module, fpu_unpack (combinational: sign, exponent and mantissa with hidden bit, plus zero/special flags), instantiated once per operand.

Verification
REQ-029 The bench SHALL check 0x40400000 - 0x3F800000 -> 0x40000000, with out_valid on the 3rd cycle after the handshake (1 ALIGN cycle, no NORM).
REQ-030 The bench SHALL check 0x3F800000 - 0x3F800000 -> 0x00000000, with no NORM cycles.
REQ-031 The bench SHALL check 0x3F800000 - 0xBF800000 -> 0x40000000 (carry path, exponent incremented) and 0x3F800000 - 0x3FC00000 -> 0xBF000000 (swap plus 1 NORM cycle).
REQ-032 The bench SHALL check 0x4B800000 - 0x3F800000 -> 0x4B800000 (operand fully shifted out, ALIGN exits at mantissa 0).
REQ-033 The bench SHALL hold out_ready=0 for 5 cycles in DONE and confirm result is stable and in_ready=0 throughout; it SHALL also assert rst mid-NORM and confirm IDLE and out_valid=0 on the next cycle.
REQ-034 The bench SHALL check 0x7F800000 - 0x3F800000 -> 0x7FC00000, and 0x00000000 - 0x40000000 -> 0xC0000000.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants for the sequential single-precision subtractor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fpu_pkg;

  // FSM encoding
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ALIGN = 3'd1;
  localparam logic [2:0] ADD   = 3'd2;
  localparam logic [2:0] NORM  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam int          MANT_W  = 24;

  // Assemble a single-precision word from sign, exponent and a mantissa
  // whose hidden bit (MSB) is dropped.
  function automatic logic [31:0] pack_fp(input logic sgn, input logic [7:0] ex,
                                          input logic [MANT_W-1:0] mant);
    return {sgn, ex, mant[MANT_W-2:0]};
  endfunction

endpackage

// File: rtl/fpu_unpack.sv
// Splits a single-precision word into sign, exponent, mantissa(+hidden) and flags.
// Latency: combinational.
// Backpressure: none.
// Ports: op (operand word) -> sgn, ex, mant, is_zero (exp==0, denormals flushed), is_special (exp==255).
module fpu_unpack
  import fpu_pkg::*;
(
  input  logic [31:0]       op,
  output logic              sgn,
  output logic [7:0]        ex,
  output logic [MANT_W-1:0] mant,
  output logic              is_zero,
  output logic              is_special
);

  assign sgn        = op[31];
  assign is_zero    = (op[30:23] == 8'h00);
  assign is_special = (op[30:23] == EXP_MAX);
  // Denormals carry no magnitude here: exponent and mantissa both read as zero.
  assign ex         = is_zero ? 8'h00 : op[30:23];
  assign mant       = is_zero ? '0 : {1'b1, op[22:0]};

endmodule

// File: rtl/fpu_sub_seq.sv
// Sequential single-precision subtractor: result = ip1 - ip2, truncating.
// Latency: 2 + align cycles + normalise cycles (NaN/Inf inputs: 1).
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
// Ports: clk, rst (sync, active-high); ip1/ip2/in_valid/in_ready operand side;
//        result/out_valid/out_ready result side.
module fpu_sub_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ip1,
  input  logic [31:0] ip2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  input  logic        out_ready,
  output logic        out_valid
);

  logic              s1, s2, z1, z2, sp1, sp2;
  logic [7:0]        e1, e2;
  logic [MANT_W-1:0] m1, m2;

  fpu_unpack u_unpack_1 (
    .op(ip1), .sgn(s1), .ex(e1), .mant(m1), .is_zero(z1), .is_special(sp1)
  );

  fpu_unpack u_unpack_2 (
    .op(ip2), .sgn(s2), .ex(e2), .mant(m2), .is_zero(z2), .is_special(sp2)
  );

  logic [2:0]        state;
  logic              sign_a, sign_b;
  logic [7:0]        exp_a, diff;
  logic [MANT_W-1:0] mant_a, mant_b;
  logic              bypass;
  logic [31:0]       result_q;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_q;

  // Operand swap: A always carries the larger {exp, mantissa} magnitude.
  // Subtraction is addition with the subtrahend's sign flipped.
  logic              op1_big;
  logic              cap_sign_a, cap_sign_b;
  logic [7:0]        cap_exp_a, cap_exp_b;
  logic [MANT_W-1:0] cap_mant_a, cap_mant_b;

  always_comb begin
    op1_big    = ({e1, m1} >= {e2, m2});
    cap_sign_a = op1_big ? s1  : ~s2;
    cap_sign_b = op1_big ? ~s2 : s1;
    cap_exp_a  = op1_big ? e1  : e2;
    cap_exp_b  = op1_big ? e2  : e1;
    cap_mant_a = op1_big ? m1  : m2;
    cap_mant_b = op1_big ? m2  : m1;
  end

  logic [MANT_W:0]   sum_w;
  logic [MANT_W-1:0] dif_w, mant_b_sh, mant_a_sh;
  logic [7:0]        exp_inc, exp_dec, cap_diff;

  assign sum_w     = {1'b0, mant_a} + {1'b0, mant_b};
  assign dif_w     = mant_a - mant_b;
  assign mant_b_sh = mant_b >> 1;
  assign mant_a_sh = mant_a << 1;
  assign exp_inc   = exp_a + 8'd1;
  assign exp_dec   = exp_a - 8'd1;
  assign cap_diff  = cap_exp_a - cap_exp_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      exp_a    <= 8'h00;
      diff     <= 8'h00;
      mant_a   <= '0;
      mant_b   <= '0;
      bypass   <= 1'b0;
      result_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bypass <= 1'b0;
            sign_a <= cap_sign_a;
            sign_b <= cap_sign_b;
            exp_a  <= cap_exp_a;
            mant_a <= cap_mant_a;
            mant_b <= cap_mant_b;
            diff   <= cap_diff;
            if (sp1 || sp2) begin
              result_q <= QNAN;
              state    <= DONE;
            end else if (z2) begin
              // Zero operands pass through ADD so latency matches the normal path.
              result_q <= ip1;
              bypass   <= 1'b1;
              state    <= ADD;
            end else if (z1) begin
              result_q <= {~ip2[31], ip2[30:0]};
              bypass   <= 1'b1;
              state    <= ADD;
            end else if ((cap_diff != 8'h00) && (cap_mant_b != '0)) begin
              state <= ALIGN;
            end else begin
              state <= ADD;
            end
          end
        end

        ALIGN: begin
          mant_b <= mant_b_sh;
          diff   <= diff - 8'd1;
          // A 24-bit mantissa empties after at most 24 shifts, bounding ALIGN.
          if ((diff == 8'd1) || (mant_b_sh == '0)) begin
            state <= ADD;
          end
        end

        ADD: begin
          if (bypass) begin
            state <= DONE;
          end else if (sign_a == sign_b) begin
            if (sum_w[MANT_W]) begin
              if (exp_inc == EXP_MAX) begin
                result_q <= {sign_a, EXP_MAX, 23'h0};
              end else begin
                result_q <= pack_fp(sign_a, exp_inc, sum_w[MANT_W:1]);
              end
            end else begin
              result_q <= pack_fp(sign_a, exp_a, sum_w[MANT_W-1:0]);
            end
            state <= DONE;
          end else begin
            if (dif_w == '0) begin
              result_q <= 32'h0;
              state    <= DONE;
            end else if (!dif_w[MANT_W-1]) begin
              mant_a <= dif_w;
              state  <= NORM;
            end else begin
              result_q <= pack_fp(sign_a, exp_a, dif_w);
              state    <= DONE;
            end
          end
        end

        NORM: begin
          if (exp_a == 8'd1) begin
            // Next step would leave the normal range: flush to signed zero.
            result_q <= {sign_a, 31'h0};
            state    <= DONE;
          end else begin
            mant_a <= mant_a_sh;
            exp_a  <= exp_dec;
            if (mant_a_sh[MANT_W-1]) begin
              result_q <= pack_fp(sign_a, exp_dec, mant_a_sh);
              state    <= DONE;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_sub_seq.sv
// Directed bench for fpu_sub_seq: operand pairs with hand-computed results and latencies.
// Latency: n/a.
// Backpressure: exercises held results with out_ready low and reset mid-operation.
module tb_fpu_sub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ip1, ip2;
  logic        in_valid, in_ready;
  logic [31:0] result;
  logic        out_ready, out_valid;

  int tests = 0;
  int fails = 0;

  fpu_sub_seq dut (
    .clk(clk), .rst(rst), .ip1(ip1), .ip2(ip2), .in_valid(in_valid),
    .in_ready(in_ready), .result(result), .out_ready(out_ready), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hand off one operand pair, measure cycles to out_valid, check result,
  // and optionally accept the result.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat, input bit accept);
    int  lat;
    bit  seen;
    @(negedge clk);
    check({tag, " in_ready"}, {31'h0, in_ready}, 32'h1);
    ip1 = a; ip2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, result, exp_res);
    if (accept) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check({tag, " out_valid drop"}, {31'h0, out_valid}, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst = 1'b1; ip1 = '0; ip2 = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", {31'h0, in_ready}, 32'h1);
    check("reset out_valid", {31'h0, out_valid}, 32'h0);
    check("reset result", result, 32'h0);

    do_op("3-1",         32'h40400000, 32'h3F800000, 32'h40000000, 3,  1'b1);
    do_op("1-1",         32'h3F800000, 32'h3F800000, 32'h00000000, 2,  1'b1);
    do_op("1-(-1)",      32'h3F800000, 32'hBF800000, 32'h40000000, 2,  1'b1);
    do_op("1-1.5",       32'h3F800000, 32'h3FC00000, 32'hBF000000, 3,  1'b1);
    do_op("shift out",   32'h4B800000, 32'h3F800000, 32'h4B800000, 26, 1'b1);
    do_op("inf-1",       32'h7F800000, 32'h3F800000, 32'h7FC00000, 1,  1'b1);
    do_op("0-2",         32'h00000000, 32'h40000000, 32'hC0000000, 2,  1'b1);
    do_op("pi-0",        32'h40490FDB, 32'h00000000, 32'h40490FDB, 2,  1'b1);
    do_op("1-denorm",    32'h3F800000, 32'h00000001, 32'h3F800000, 2,  1'b1);
    do_op("long norm",   32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 26, 1'b1);
    do_op("flush",       32'h80C00000, 32'h80800000, 32'h80000000, 3,  1'b1);
    do_op("overflow",    32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 2,  1'b1);

    // Result held in DONE while the consumer stalls; new operands are ignored.
    do_op("hold", 32'h40400000, 32'h3F800000, 32'h40000000, 3, 1'b0);
    ip1 = 32'h3F800000; ip2 = 32'hBF800000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold result", result, 32'h40000000);
      check("hold in_ready", {31'h0, in_ready}, 32'h0);
      check("hold out_valid", {31'h0, out_valid}, 32'h1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("hold release out_valid", {31'h0, out_valid}, 32'h0);
    check("hold release in_ready", {31'h0, in_ready}, 32'h1);
    check("hold result kept", result, 32'h40000000);

    // Reset in the middle of a 23-cycle NORM run.
    @(negedge clk);
    ip1 = 32'h3F800000; ip2 = 32'h3F7FFFFF; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid-norm out_valid", {31'h0, out_valid}, 32'h0);
    check("mid-norm in_ready", {31'h0, in_ready}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post-rst in_ready", {31'h0, in_ready}, 32'h1);
    check("post-rst out_valid", {31'h0, out_valid}, 32'h0);
    check("post-rst result", result, 32'h0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("post-rst no pulse", pulses, 0);

    do_op("recover", 32'h40400000, 32'h3F800000, 32'h40000000, 3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
